// File: rtl/plot_sink.sv
// Plot request sink: bounds-checks incoming pixel plots, buffers them in a small FIFO
// and drains them into a 160x120x3 framebuffer, with a full-screen clear engine and readback.
module plot_sink #(
   parameter int FIFO_DEPTH = 4,
   parameter int SCR_W      = 160,
   parameter int SCR_H      = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   input  logic        clear_start,
   input  logic [2:0]  clear_colour,
   output logic        clear_done,
   output logic        busy,
   output logic        overflow,
   output logic [15:0] plot_count,
   input  logic [7:0]  rd_x,
   input  logic [6:0]  rd_y,
   output logic [2:0]  rd_colour
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FB_SIZE = SCR_W * SCR_H;
   localparam logic [14:0] LAST_ADDR = 15'(FB_SIZE - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [14:0]   r_clr_addr;
   logic [2:0]    r_clr_colour;

   logic [17:0]   r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          r_overflow;
   logic [15:0]   r_plot_count;

   logic [2:0]    r_fb [FB_SIZE];
   logic [2:0]    r_rd_colour;

   logic          w_in_bounds;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [17:0]   w_head;
   logic [14:0]   w_pop_addr;
   logic          w_clr_we;
   logic          w_fb_we;
   logic [14:0]   w_fb_addr;
   logic [2:0]    w_fb_data;
   logic          w_rd_in_bounds;
   logic [14:0]   w_rd_addr;

   // ---------------- plot FIFO ----------------
   assign w_in_bounds = (32'(vga_x) < 32'(SCR_W)) && (32'(vga_y) < 32'(SCR_H));
   assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
   // Fullness is judged before any pop this cycle, so a full FIFO always drops.
   assign w_push      = vga_plot && w_in_bounds && !w_full;
   assign w_pop       = (r_state != S_CLEAR) && (r_count != '0);
   assign w_head      = r_fifo[r_rd_ptr];
   assign w_pop_addr  = 15'(w_head[9:3]) * 15'(SCR_W) + 15'(w_head[17:10]);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {vga_x, vga_y, vga_colour};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_plot_count <= 16'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + PW'(1);
            r_plot_count <= r_plot_count + 16'd1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (PW+1)'(1);
         end
         if (vga_plot && w_in_bounds && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------- clear FSM ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (clear_start) w_state_next = S_CLEAR;
         S_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_next = S_DONE;
         S_DONE:  if (!clear_start) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_clr_addr <= 15'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && clear_start) begin
            r_clr_addr   <= 15'd0;
            r_clr_colour <= clear_colour;
         end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 15'd1;
         end
      end
   end

   // ---------------- framebuffer ----------------
   // Draining is blocked during CLEAR, so the clear engine owns the single write port there.
   assign w_clr_we  = (r_state == S_CLEAR);
   assign w_fb_we   = !rst && (w_clr_we || w_pop);
   assign w_fb_addr = w_clr_we ? r_clr_addr : w_pop_addr;
   assign w_fb_data = w_clr_we ? r_clr_colour : w_head[2:0];

   always_ff @(posedge clk) begin
      if (w_fb_we) begin
         r_fb[w_fb_addr] <= w_fb_data;
      end
   end

   assign w_rd_in_bounds = (32'(rd_x) < 32'(SCR_W)) && (32'(rd_y) < 32'(SCR_H));
   assign w_rd_addr      = 15'(rd_y) * 15'(SCR_W) + 15'(rd_x);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_colour <= 3'b000;
      end else if (w_rd_in_bounds) begin
         r_rd_colour <= r_fb[w_rd_addr];
      end else begin
         r_rd_colour <= 3'b000;
      end
   end

   assign clear_done = (r_state == S_DONE);
   assign busy       = (r_state == S_CLEAR) || (r_count != '0);
   assign overflow   = r_overflow;
   assign plot_count = r_plot_count;
   assign rd_colour  = r_rd_colour;

endmodule
